load_store_memory_stage: RTL and testbench

//  Memory-access stage of the load/store pipe. Takes one packed control word per cycle. Performs a

---
 rtl/load_store_memory_stage_pkg.sv | 62 ++++++
 rtl/load_store_memory_stage_data_ram.sv | 27 ++
 rtl/load_store_memory_stage.sv | 136 +++++++++++++
 tb/tb_load_store_memory_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_memory_stage_pkg.sv
// Shared widths, control-word layout and mux encodings for the load/store memory stage.
package load_store_memory_stage_pkg;

    localparam int TAG_W     = 4;
    localparam int REG_W     = 4;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int LD_MUX_W  = 3;
    localparam int ST_MUX_W  = 2;
    localparam int WEN_W     = DATA_W / 8;
    localparam int MEM_WORDS = 256;
    localparam int MEM_IDX_W = $clog2(MEM_WORDS);

    // Control-word bit offsets, LSB first (start is bit 0).
    localparam int CW_START_BIT   = 0;
    localparam int CW_LSM_BIT     = 1;
    localparam int CW_CONF_BIT    = 2;
    localparam int CW_WEN_LSB     = 3;
    localparam int CW_ST_MUX_LSB  = CW_WEN_LSB + WEN_W;
    localparam int CW_LD_MUX_LSB  = CW_ST_MUX_LSB + ST_MUX_W;
    localparam int CW_SWP_BIT     = CW_LD_MUX_LSB + LD_MUX_W;
    localparam int CW_ADDR_LSB    = CW_SWP_BIT + 1;
    localparam int CW_RN_DATA_LSB = CW_ADDR_LSB + ADDR_W;
    localparam int CW_ST_DATA_LSB = CW_RN_DATA_LSB + DATA_W;
    localparam int CW_RN_ADDR_LSB = CW_ST_DATA_LSB + DATA_W;
    localparam int CW_RD_ADDR_LSB = CW_RN_ADDR_LSB + REG_W;
    localparam int CW_TAG_LSB     = CW_RD_ADDR_LSB + REG_W;
    localparam int CW_W           = CW_TAG_LSB + TAG_W;

    typedef enum logic [ST_MUX_W-1:0] {
        ST_WORD     = 2'd0,
        ST_BYTE     = 2'd1,
        ST_HALF     = 2'd2,
        ST_WORD_ALT = 2'd3
    } st_mux_e;

    typedef enum logic [LD_MUX_W-1:0] {
        LD_WORD  = 3'd0,
        LD_UBYTE = 3'd1,
        LD_UHALF = 3'd2,
        LD_SBYTE = 3'd3,
        LD_SHALF = 3'd4
    } ld_mux_e;

    // Field order matches the packed control word, MSB first.
    typedef struct packed {
        logic [TAG_W-1:0]    instr_tag;
        logic [REG_W-1:0]    rd_addr;
        logic [REG_W-1:0]    rn_addr;
        logic [DATA_W-1:0]   store_rd_data;
        logic [DATA_W-1:0]   rn_data;
        logic [ADDR_W-1:0]   mem_addr;
        logic                swp_ctrl;
        logic [LD_MUX_W-1:0] ld_mux;
        logic [ST_MUX_W-1:0] st_mux;
        logic [WEN_W-1:0]    w_en;
        logic                instr_confirmed;
        logic                lsm_en;
        logic                start;
    } ctrl_word_t;

endpackage

// File: rtl/load_store_memory_stage_data_ram.sv
// Byte-lane data RAM: synchronous byte-enabled write, asynchronous word read.
// The read port shows the pre-edge word, so a read and write at the same
// edge give read-before-write behaviour.
module lsms_data_ram
    import load_store_memory_stage_pkg::*;
(
    input  logic                 i_clk,
    input  logic [WEN_W-1:0]     i_wr_en,
    input  logic [MEM_IDX_W-1:0] i_idx,
    input  logic [DATA_W-1:0]    i_wr_data,
    output logic [DATA_W-1:0]    o_rd_data
);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    // Write each enabled byte lane of the addressed word.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < WEN_W; i++) begin
            if (i_wr_en[i]) begin
                r_mem[i_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
            end
        end
    end

    assign o_rd_data = r_mem[i_idx];

endmodule

// File: rtl/load_store_memory_stage.sv
// Memory-access stage of the load/store pipe: one single-cycle load/store/swap
// per cycle against the byte-lane data RAM, with registered results to writeback.
module load_store_memory_stage
    import load_store_memory_stage_pkg::*;
(
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [CW_W-1:0]     load_store_memory_stage_control_word_in,
    output logic [DATA_W-1:0]   data_frm_mem_out,
    output logic                load_store_multiple_en_out,
    output logic                load_store_memory_stage_complete_out,
    output logic                load_store_memory_stage_instr_confirmed_out,
    output logic [DATA_W-1:0]   load_store_rn_data_out,
    output logic [REG_W-1:0]    load_store_rd_addr_out,
    output logic [REG_W-1:0]    load_store_rn_addr_out,
    output logic [TAG_W-1:0]    load_store_instr_tag_out
);

    // Replicate the store operand across lanes; w_en alone picks which lanes land.
    function automatic logic [DATA_W-1:0] store_replicate(
        input logic [ST_MUX_W-1:0] sel,
        input logic [DATA_W-1:0]   d
    );
        logic [DATA_W-1:0] res;
        case (sel)
            ST_BYTE: res = {(DATA_W/8){d[7:0]}};
            ST_HALF: res = {(DATA_W/16){d[15:0]}};
            default: res = d;
        endcase
        return res;
    endfunction

    // Format the old word: rotate for unaligned word loads, extract and extend sub-words.
    function automatic logic [DATA_W-1:0] load_format(
        input logic [LD_MUX_W-1:0] sel,
        input logic [1:0]          lane,
        input logic [DATA_W-1:0]   w
    );
        logic [2*DATA_W-1:0]      dbl;
        logic [DATA_W-1:0]        rot;
        logic signed [7:0]        sbyte;
        logic signed [15:0]       shalf;
        logic signed [DATA_W-1:0] ext;
        logic [DATA_W-1:0]        res;
        dbl   = {w, w} >> {lane, 3'b000};
        rot   = dbl[DATA_W-1:0];
        // After rotation the addressed byte sits in lane 0.
        sbyte = rot[7:0];
        shalf = lane[1] ? w[31:16] : w[15:0];
        case (sel)
            LD_UBYTE: res = {{(DATA_W-8){1'b0}}, sbyte};
            LD_UHALF: res = {{(DATA_W-16){1'b0}}, shalf};
            LD_SBYTE: begin
                ext = sbyte;
                res = ext;
            end
            LD_SHALF: begin
                ext = shalf;
                res = ext;
            end
            default:  res = rot;
        endcase
        return res;
    endfunction

    ctrl_word_t             w_cw_p0;
    logic [MEM_IDX_W-1:0]   w_idx_p0;
    logic [1:0]             w_lane_p0;
    logic [WEN_W-1:0]       w_wen_p0;
    logic [DATA_W-1:0]      w_st_data_p0;
    logic [DATA_W-1:0]      w_old_word_p0;
    logic [DATA_W-1:0]      w_ld_data_p0;
    logic                   w_unused_p0;

    logic [DATA_W-1:0]      r_data_p1;
    logic                   r_lsm_en_p1;
    logic                   r_complete_p1;
    logic                   r_confirmed_p1;
    logic [DATA_W-1:0]      r_rn_data_p1;
    logic [REG_W-1:0]       r_rd_addr_p1;
    logic [REG_W-1:0]       r_rn_addr_p1;
    logic [TAG_W-1:0]       r_tag_p1;

    // ---- p0: unpack control word, address RAM, format store/load data ----
    assign w_cw_p0      = ctrl_word_t'(load_store_memory_stage_control_word_in);
    assign w_idx_p0     = w_cw_p0.mem_addr[MEM_IDX_W+1:2];
    assign w_lane_p0    = w_cw_p0.mem_addr[1:0];
    assign w_wen_p0     = w_cw_p0.start ? w_cw_p0.w_en : '0;
    assign w_st_data_p0 = store_replicate(w_cw_p0.st_mux, w_cw_p0.store_rd_data);
    assign w_ld_data_p0 = load_format(w_cw_p0.ld_mux, w_lane_p0, w_old_word_p0);
    // Upper address bits wrap the RAM index; a swap is an ordinary read-then-write.
    assign w_unused_p0  = ^{w_cw_p0.mem_addr[ADDR_W-1:MEM_IDX_W+2], w_cw_p0.swp_ctrl};

    lsms_data_ram u_ram (
        .i_clk     (clk_in),
        .i_wr_en   (w_wen_p0),
        .i_idx     (w_idx_p0),
        .i_wr_data (w_st_data_p0),
        .o_rd_data (w_old_word_p0)
    );

    // ---- p1: capture results on start; complete pulses for exactly one cycle ----
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_data_p1      <= '0;
            r_lsm_en_p1    <= 1'b0;
            r_complete_p1  <= 1'b0;
            r_confirmed_p1 <= 1'b0;
            r_rn_data_p1   <= '0;
            r_rd_addr_p1   <= '0;
            r_rn_addr_p1   <= '0;
            r_tag_p1       <= '0;
        end else begin
            r_complete_p1 <= w_cw_p0.start;
            if (w_cw_p0.start) begin
                r_data_p1      <= w_ld_data_p0;
                r_lsm_en_p1    <= w_cw_p0.lsm_en;
                r_confirmed_p1 <= w_cw_p0.instr_confirmed;
                r_rn_data_p1   <= w_cw_p0.rn_data;
                r_rd_addr_p1   <= w_cw_p0.rd_addr;
                r_rn_addr_p1   <= w_cw_p0.rn_addr;
                r_tag_p1       <= w_cw_p0.instr_tag;
            end
        end
    end

    assign data_frm_mem_out                            = r_data_p1;
    assign load_store_multiple_en_out                  = r_lsm_en_p1;
    assign load_store_memory_stage_complete_out        = r_complete_p1;
    assign load_store_memory_stage_instr_confirmed_out = r_confirmed_p1;
    assign load_store_rn_data_out                      = r_rn_data_p1;
    assign load_store_rd_addr_out                      = r_rd_addr_p1;
    assign load_store_rn_addr_out                      = r_rn_addr_p1;
    assign load_store_instr_tag_out                    = r_tag_p1;

endmodule

// File: tb/tb_load_store_memory_stage.sv
// Self-checking bench for load_store_memory_stage: directed table, corner
// sequences, and randomized traffic against a byte-array memory model.
module tb_load_store_memory_stage;

    localparam int CW_W = 121;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic [CW_W-1:0]   cw_in;
    logic [31:0]       data_out;
    logic              lsm_out, complete_out, conf_out;
    logic [31:0]       rn_data_out;
    logic [3:0]        rd_addr_out, rn_addr_out, tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl [1024];

    always #5 clk_in = ~clk_in;

    load_store_memory_stage dut (
        .clk_in                                      (clk_in),
        .reset_in                                    (reset_in),
        .load_store_memory_stage_control_word_in     (cw_in),
        .data_frm_mem_out                            (data_out),
        .load_store_multiple_en_out                  (lsm_out),
        .load_store_memory_stage_complete_out        (complete_out),
        .load_store_memory_stage_instr_confirmed_out (conf_out),
        .load_store_rn_data_out                      (rn_data_out),
        .load_store_rd_addr_out                      (rd_addr_out),
        .load_store_rn_addr_out                      (rn_addr_out),
        .load_store_instr_tag_out                    (tag_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, ".data"},     data_out,            32'h0);
        check({pfx, ".lsm"},      {31'h0, lsm_out},    32'h0);
        check({pfx, ".complete"}, {31'h0, complete_out}, 32'h0);
        check({pfx, ".conf"},     {31'h0, conf_out},   32'h0);
        check({pfx, ".rn_data"},  rn_data_out,         32'h0);
        check({pfx, ".rd"},       {28'h0, rd_addr_out}, 32'h0);
        check({pfx, ".rn"},       {28'h0, rn_addr_out}, 32'h0);
        check({pfx, ".tag"},      {28'h0, tag_out},    32'h0);
    endtask

    function automatic logic [CW_W-1:0] pack(
        input logic [3:0] tag, input logic [3:0] rd, input logic [3:0] rn,
        input logic [31:0] sd, input logic [31:0] rnd, input logic [31:0] addr,
        input logic swp, input logic [2:0] ld, input logic [1:0] st, input logic [3:0] wen,
        input logic conf, input logic lsm, input logic start);
        return {tag, rd, rn, sd, rnd, addr, swp, ld, st, wen, conf, lsm, start};
    endfunction

    task automatic run_op(input logic [CW_W-1:0] cw);
        cw_in = cw;
        @(posedge clk_in);
        #1;
    endtask

    // Reference load: assembled byte by byte from the model's little-endian memory.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] ld);
        int base = int'(addr[9:2]) * 4;
        int lane = int'(addr[1:0]);
        int hb   = base + (lane / 2) * 2;
        logic [31:0] r;
        case (ld)
            3'd1: r = {24'h0, mdl[base+lane]};
            3'd2: r = {16'h0, mdl[hb+1], mdl[hb]};
            3'd3: r = {{24{mdl[base+lane][7]}}, mdl[base+lane]};
            3'd4: r = {{16{mdl[hb+1][7]}}, mdl[hb+1], mdl[hb]};
            default: for (int k = 0; k < 4; k++) r[8*k +: 8] = mdl[base + ((lane + k) % 4)];
        endcase
        return r;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] st,
                               input logic [3:0] wen, input logic [31:0] sd);
        int base = int'(addr[9:2]) * 4;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                if (st == 2'd1)      mdl[base+i] = sd[7:0];
                else if (st == 2'd2) mdl[base+i] = sd[8*(i%2) +: 8];
                else                 mdl[base+i] = sd[8*i +: 8];
            end
        end
    endtask

    typedef struct {
        logic [31:0] sd;
        logic [31:0] addr;
        logic        swp;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [3:0]  wen;
        logic        start;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mkv(input logic [31:0] sd, input logic [31:0] addr, input logic swp,
                                 input logic [2:0] ld, input logic [1:0] st, input logic [3:0] wen,
                                 input logic start, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.sd = sd; v.addr = addr; v.swp = swp; v.ld = ld; v.st = st; v.wen = wen;
        v.start = start; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        int          last_i;
        logic [3:0]  tag, rd, rn;
        logic [31:0] rnd, addr, sd;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [3:0]  wen;
        logic        swp, start, conf, lsm;
        logic [31:0] exp_data, exp_rnd;
        logic [3:0]  exp_tag, exp_rd;

        // Reset phase: outputs zero while held and after release with start=0.
        reset_in = 1'b1;
        cw_in    = '0;
        #100;
        check_all_zero("reset_held");
        reset_in = 1'b0;
        run_op(pack(4'h5, 4'h6, 4'h7, 32'hDEAD, 32'hBEEF, 32'h4, 1'b0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b1, 1'b0));
        run_op(pack(4'h5, 4'h6, 4'h7, 32'hDEAD, 32'hBEEF, 32'h4, 1'b0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b1, 1'b0));
        check_all_zero("idle_after_reset");

        // Directed table.
        tbl.push_back(mkv(32'hAABBCCDD, 32'h4,   1'b0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0, 32'h0));
        tbl.push_back(mkv(32'h0,        32'h4,   1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 32'hAABBCCDD));
        tbl.push_back(mkv(32'h0,        32'h6,   1'b0, 3'd1, 2'd0, 4'h0, 1'b1, 1'b1, 32'h000000BB));
        tbl.push_back(mkv(32'h0,        32'h7,   1'b0, 3'd3, 2'd0, 4'h0, 1'b1, 1'b1, 32'hFFFFFFAA));
        tbl.push_back(mkv(32'h0,        32'h6,   1'b0, 3'd4, 2'd0, 4'h0, 1'b1, 1'b1, 32'hFFFFAABB));
        tbl.push_back(mkv(32'h0,        32'h4,   1'b0, 3'd2, 2'd0, 4'h0, 1'b1, 1'b1, 32'h0000CCDD));
        tbl.push_back(mkv(32'h0,        32'h4,   1'b0, 3'd1, 2'd0, 4'hF, 1'b0, 1'b1, 32'h0000CCDD));
        tbl.push_back(mkv(32'h77665512, 32'h5,   1'b0, 3'd0, 2'd1, 4'h2, 1'b1, 1'b1, 32'hDDAABBCC));
        tbl.push_back(mkv(32'h0,        32'h4,   1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 32'hAABB12DD));
        tbl.push_back(mkv(32'h11223344, 32'h4,   1'b1, 3'd0, 2'd0, 4'hF, 1'b1, 1'b1, 32'hAABB12DD));
        tbl.push_back(mkv(32'h0,        32'h4,   1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 32'h11223344));
        tbl.push_back(mkv(32'h99995566, 32'h6,   1'b0, 3'd0, 2'd2, 4'hC, 1'b1, 1'b1, 32'h33441122));
        tbl.push_back(mkv(32'h0,        32'h404, 1'b0, 3'd5, 2'd0, 4'h0, 1'b1, 1'b1, 32'h55663344));
        tbl.push_back(mkv(32'hCAFEF00D, 32'h4,   1'b0, 3'd2, 2'd3, 4'h5, 1'b1, 1'b1, 32'h00003344));
        tbl.push_back(mkv(32'h0,        32'h4,   1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 32'h55FE330D));
        tbl.push_back(mkv(32'h0,        32'h7,   1'b0, 3'd1, 2'd0, 4'h0, 1'b1, 1'b1, 32'h00000055));
        tbl.push_back(mkv(32'hFFFFFFFF, 32'h4,   1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 32'h55FE330D));
        tbl.push_back(mkv(32'h0,        32'h5,   1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 32'h0D55FE33));

        last_i = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            int j;
            j = i;
            run_op(pack(4'(i), ~4'(i), 4'(i + 3), tbl[i].sd, 32'hC0DE0000 | 32'(i), tbl[i].addr,
                        tbl[i].swp, tbl[i].ld, tbl[i].st, tbl[i].wen, j[0], j[1], tbl[i].start));
            if (tbl[i].start) last_i = i;
            j = last_i;
            if (tbl[i].chk) check($sformatf("vec%0d.data", i), data_out, tbl[i].exp);
            check($sformatf("vec%0d.complete", i), {31'h0, complete_out}, {31'h0, tbl[i].start});
            check($sformatf("vec%0d.tag", i),     {28'h0, tag_out},     {28'h0, 4'(j)});
            check($sformatf("vec%0d.rd", i),      {28'h0, rd_addr_out}, {28'h0, ~4'(j)});
            check($sformatf("vec%0d.rn", i),      {28'h0, rn_addr_out}, {28'h0, 4'(j + 3)});
            check($sformatf("vec%0d.rn_data", i), rn_data_out,          32'hC0DE0000 | 32'(j));
            check($sformatf("vec%0d.conf", i),    {31'h0, conf_out},    {31'h0, j[0]});
            check($sformatf("vec%0d.lsm", i),     {31'h0, lsm_out},     {31'h0, j[1]});
        end

        // Three back-to-back starts, then idle: complete high exactly three cycles.
        for (int k = 0; k < 3; k++) begin
            run_op(pack(4'(k + 9), 4'h1, 4'h2, 32'h0, 32'h0, 32'h4, 1'b0, 3'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1));
            check($sformatf("stream%0d.complete", k), {31'h0, complete_out}, 32'h1);
            check($sformatf("stream%0d.tag", k), {28'h0, tag_out}, {28'h0, 4'(k + 9)});
        end
        run_op(pack(4'hF, 4'h1, 4'h2, 32'h0, 32'h0, 32'h4, 1'b0, 3'd0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
        check("stream_idle.complete", {31'h0, complete_out}, 32'h0);
        check("stream_idle.tag", {28'h0, tag_out}, 32'hB);

        // Reset asserted mid-stream clears outputs without waiting for a clock edge.
        run_op(pack(4'h3, 4'h4, 4'h5, 32'h0, 32'h1234, 32'h4, 1'b0, 3'd0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1));
        check("prereset.complete", {31'h0, complete_out}, 32'h1);
        #2;
        reset_in = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk_in);
        #1;
        check_all_zero("reset_hold_edge");
        @(negedge clk_in);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Randomized traffic: fill every word first, then mixed operations.
        for (int w = 0; w < 256; w++) begin
            addr = {22'($urandom), 8'(w), 2'b00};
            sd   = $urandom;
            model_store(addr, 2'd0, 4'hF, sd);
            run_op(pack(4'h0, 4'h0, 4'h0, sd, 32'h0, addr, 1'b0, 3'd0, 2'd0, 4'hF, 1'b0, 1'b0, 1'b1));
        end
        check("fill.complete", {31'h0, complete_out}, 32'h1);

        exp_data = '0; exp_rnd = '0; exp_tag = '0; exp_rd = '0;
        for (int n = 0; n < 300; n++) begin
            start = (n == 0) || ($urandom_range(0, 3) != 0);
            tag  = 4'($urandom); rd = 4'($urandom); rn = 4'($urandom);
            rnd  = $urandom; addr = $urandom; sd = $urandom;
            swp  = 1'($urandom); ld = 3'($urandom_range(0, 7)); st = 2'($urandom);
            wen  = 4'($urandom); conf = 1'($urandom); lsm = 1'($urandom);
            if (start) begin
                exp_data = model_load(addr, ld);
                model_store(addr, st, wen, sd);
                exp_tag = tag;
                exp_rd  = rd;
                exp_rnd = rnd;
            end
            run_op(pack(tag, rd, rn, sd, rnd, addr, swp, ld, st, wen, conf, lsm, start));
            check($sformatf("rand%0d.data", n), data_out, exp_data);
            check($sformatf("rand%0d.complete", n), {31'h0, complete_out}, {31'h0, start});
            check($sformatf("rand%0d.tag", n), {28'h0, tag_out}, {28'h0, exp_tag});
            check($sformatf("rand%0d.rd", n), {28'h0, rd_addr_out}, {28'h0, exp_rd});
            check($sformatf("rand%0d.rn_data", n), rn_data_out, exp_rnd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
